// File: rtl/branch_predictor.sv
// Fetch-side predictor: a table of 2-bit saturating counters indexed by PC, with
// the prediction carried into ID and resolved there. Optional stats: BP_STATS_EN.
module branch_predictor #(
    parameter int         INDEX_W      = 6,
    parameter logic [1:0] COUNTER_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    output logic        predict_takenF,
    input  logic        branchD,
    input  logic        actual_takenD,
    output logic        pred_takenD,
    output logic        mispredictD,
    output logic [31:0] br_countD,
    output logic [31:0] mp_countD
);
    localparam int DEPTH = 1 << INDEX_W;

    logic [1:0]         tbl [DEPTH];
    logic [INDEX_W-1:0] idxF;
    logic [INDEX_W-1:0] idxD;
    logic               validD;
    logic               resolveD;

    // Word-aligned PC bits only; stallF is irrelevant because a stalled fetch never consumes the prediction.
    wire unused_ok = ^{pcF[31:INDEX_W+2], pcF[1:0], stallF};

    assign idxF           = pcF[INDEX_W+1:2];
    assign predict_takenF = tbl[idxF][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idxD        <= '0;
            pred_takenD <= 1'b0;
            validD      <= 1'b0;
        end else if (flushD) begin
            validD      <= 1'b0;
            pred_takenD <= 1'b0;
        end else if (!stallD) begin
            idxD        <= idxF;
            pred_takenD <= predict_takenF;
            validD      <= 1'b1;
        end
    end

    // Comparator inputs may still be settling through forwarding while ID is stalled.
    assign resolveD    = branchD & validD & ~stallD;
    assign mispredictD = resolveD & (pred_takenD != actual_takenD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= COUNTER_INIT;
            end
        end else if (resolveD) begin
            if (actual_takenD) begin
                if (tbl[idxD] != 2'b11) begin
                    tbl[idxD] <= tbl[idxD] + 2'd1;
                end
            end else begin
                if (tbl[idxD] != 2'b00) begin
                    tbl[idxD] <= tbl[idxD] - 2'd1;
                end
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_countD <= '0;
            mp_countD <= '0;
        end else begin
            if (resolveD && br_countD != 32'hFFFF_FFFF) begin
                br_countD <= br_countD + 32'd1;
            end
            if (mispredictD && mp_countD != 32'hFFFF_FFFF) begin
                mp_countD <= mp_countD + 32'd1;
            end
        end
    end
`else
    assign br_countD = '0;
    assign mp_countD = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a counter-table model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = 32'h0040_0010;
    logic        stallF = 1'b0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        branchD = 1'b0;
    logic        actual_takenD = 1'b0;
    logic        predict_takenF;
    logic        pred_takenD;
    logic        mispredictD;
    logic [31:0] br_countD;
    logic [31:0] mp_countD;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.INDEX_W(6), .COUNTER_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .predict_takenF(predict_takenF), .branchD(branchD),
        .actual_takenD(actual_takenD), .pred_takenD(pred_takenD),
        .mispredictD(mispredictD), .br_countD(br_countD), .mp_countD(mp_countD)
    );

    always #5 clk = ~clk;

    // Model: integer counters 0..3 per entry, taken when >= 2.
    int cnt [64] = '{default: 1};
    int m_idx = 0;
    int m_pred = 0;
    int m_valid = 0;
    longint m_br = 0;
    longint m_mp = 0;

    function automatic int pc_index(logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) cnt[i] = 1;
            m_idx = 0; m_pred = 0; m_valid = 0; m_br = 0; m_mp = 0;
        end else begin
            int p;
            int res;
            p = (cnt[pc_index(pcF)] >= 2) ? 1 : 0;
            res = (branchD && m_valid != 0 && !stallD) ? 1 : 0;
            if (res != 0) begin
                m_br = m_br + 1;
                if (m_pred != int'(actual_takenD)) m_mp = m_mp + 1;
                if (actual_takenD) cnt[m_idx] = (cnt[m_idx] < 3) ? cnt[m_idx] + 1 : 3;
                else               cnt[m_idx] = (cnt[m_idx] > 0) ? cnt[m_idx] - 1 : 0;
            end
            if (flushD) begin
                m_valid = 0; m_pred = 0;
            end else if (!stallD) begin
                m_idx = pc_index(pcF); m_pred = p; m_valid = 1;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_mp;
        exp_mp = branchD && m_valid != 0 && !stallD && (m_pred != int'(actual_takenD));
        chk("model predict_takenF", {31'd0, predict_takenF}, (cnt[pc_index(pcF)] >= 2) ? 32'd1 : 32'd0);
        chk("model pred_takenD", {31'd0, pred_takenD}, 32'(m_pred));
        chk("model mispredictD", {31'd0, mispredictD}, {31'd0, exp_mp});
`ifdef BP_STATS_EN
        chk("model br_countD", br_countD, 32'(m_br));
        chk("model mp_countD", mp_countD, 32'(m_mp));
`else
        chk("model br_countD", br_countD, 32'd0);
        chk("model mp_countD", mp_countD, 32'd0);
`endif
    end

    task automatic drive(logic [31:0] pc, logic std, logic fl, logic br, logic act);
        @(posedge clk);
        #1;
        pcF = pc; stallF = std; stallD = std; flushD = fl; branchD = br; actual_takenD = act;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset state and first misprediction on entry 4
        settle();
        chk("reset predict_takenF", {31'd0, predict_takenF}, 32'd0);
        chk("reset mispredictD", {31'd0, mispredictD}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        drive(32'h0040_0010, 0, 0, 0, 0);
        drive(32'h0040_0080, 0, 0, 1, 1);
        settle();
        chk("first mispredict", {31'd0, mispredictD}, 32'd1);
        drive(32'h0040_0010, 0, 0, 0, 0);
        settle();
        chk("entry4 weak taken", {31'd0, predict_takenF}, 32'd1);

        // Saturation on entry 8
        drive(32'h0040_0020, 0, 0, 0, 0);
        repeat (4) drive(32'h0040_0020, 0, 0, 1, 1);
        drive(32'h0040_0020, 0, 0, 1, 0);
        settle();
        chk("sat not-taken mispredict", {31'd0, mispredictD}, 32'd1);
        chk("sat predict before update", {31'd0, predict_takenF}, 32'd1);
        drive(32'h0040_0020, 0, 0, 0, 0);
        settle();
        chk("sat 10 still taken", {31'd0, predict_takenF}, 32'd1);

        // Stall masks resolution; release gives exactly one update
        drive(32'h0040_0030, 0, 0, 0, 0);
        drive(32'h0040_0030, 1, 0, 1, 1);
        settle(); chk("stall mask 1", {31'd0, mispredictD}, 32'd0);
        drive(32'h0040_0030, 1, 0, 1, 0);
        settle(); chk("stall mask 2", {31'd0, mispredictD}, 32'd0);
        drive(32'h0040_0030, 1, 0, 1, 1);
        settle(); chk("stall mask 3", {31'd0, mispredictD}, 32'd0);
        chk("stall no update", {31'd0, predict_takenF}, 32'd0);
        drive(32'h0040_0030, 0, 0, 1, 1);
        settle(); chk("stall release mispredict", {31'd0, mispredictD}, 32'd1);
        drive(32'h0040_0030, 0, 0, 1, 0);
        settle();
        chk("stall one update", {31'd0, predict_takenF}, 32'd1);
        chk("stall second resolve ok", {31'd0, mispredictD}, 32'd0);
        drive(32'h0040_0030, 0, 0, 0, 0);
        settle(); chk("stall back to weak NT", {31'd0, predict_takenF}, 32'd0);

        // Flush wins over stall
        drive(32'h0040_0040, 0, 0, 0, 0);
        drive(32'h0040_0040, 1, 1, 1, 1);
        drive(32'h0040_0040, 0, 0, 1, 1);
        settle();
        chk("flush mispredict", {31'd0, mispredictD}, 32'd0);
        chk("flush pred_takenD", {31'd0, pred_takenD}, 32'd0);
        drive(32'h0040_0040, 0, 0, 0, 0);
        settle(); chk("flush no table change", {31'd0, predict_takenF}, 32'd0);

        // Aliasing: 0x00400004 and 0x00400104 share entry 1
        drive(32'h0040_0004, 0, 0, 0, 0);
        drive(32'h0040_0004, 0, 0, 1, 1);
        drive(32'h0040_0004, 0, 0, 1, 1);
        drive(32'h0040_0104, 0, 0, 0, 0);
        settle(); chk("alias predict", {31'd0, predict_takenF}, 32'd1);

        // Same-cycle read and update of entry 3 has no bypass
        drive(32'h0040_000C, 0, 0, 0, 0);
        drive(32'h0040_000C, 0, 0, 1, 1);
        settle(); chk("same-cycle old value", {31'd0, predict_takenF}, 32'd0);
        drive(32'h0040_000C, 0, 0, 0, 0);
        settle(); chk("same-cycle new value", {31'd0, predict_takenF}, 32'd1);

        // Statistics: fresh reset, then 10 branches, 3 taken (all predicted NT)
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        drive(32'h0040_0200, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(32'h0040_0200 + 32'(k * 4), 0, 0, 1, (k == 2 || k == 5 || k == 9));
        end
        drive(32'h0040_0300, 0, 0, 0, 0);
        settle();
`ifdef BP_STATS_EN
        chk("stats br_countD", br_countD, 32'd10);
        chk("stats mp_countD", mp_countD, 32'd3);
`else
        chk("stats br_countD tied", br_countD, 32'd0);
        chk("stats mp_countD tied", mp_countD, 32'd0);
`endif
        // Async reset while a mispredict is pending
        drive(32'h0040_0300, 0, 0, 1, 1);
        settle();
        chk("pre-reset mispredict", {31'd0, mispredictD}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async reset mispredict", {31'd0, mispredictD}, 32'd0);
        chk("async reset br_countD", br_countD, 32'd0);
        chk("async reset mp_countD", mp_countD, 32'd0);
        chk("async reset pred_takenD", {31'd0, pred_takenD}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        drive(32'h0040_0010, 0, 0, 0, 0);
        settle(); chk("post reset entry4", {31'd0, predict_takenF}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
